// File: rtl/decoder_dense_acc.sv
// Dense-layer accumulator: sums NUM_TERMS signed products plus a bias, then rounds, shifts and saturates.
// Optional DECODER_ACC_RELU_EN clamps negative results to zero after clipping.
module decoder_dense_acc #(
    parameter int PROD_WIDTH = 26,
    parameter int ACC_WIDTH  = 34,
    parameter int NUM_TERMS  = 64,
    parameter int SHIFT      = 10,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    input  logic [PROD_WIDTH-1:0] bias_tdata,
    output logic [OUT_WIDTH-1:0]  res_tdata,
    output logic                  res_sat,
    output logic                  res_tvalid,
    input  logic                  res_tready,
    output logic                  busy
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam int SUM_W = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);
    localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [SUM_W-1:0] MAX_OUT  = SUM_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_OUT  = ~MAX_OUT;

    typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} state_t;

    state_t                       state_reg, state_next;
    logic signed [ACC_WIDTH-1:0]  acc_reg, acc_next;
    logic        [CNT_W-1:0]      cnt_reg, cnt_next;
    logic        [OUT_WIDTH-1:0]  res_data_reg;
    logic                         res_sat_reg;

    logic signed [ACC_WIDTH-1:0]  prod_ext, bias_ext;
    logic signed [SUM_W-1:0]      rnd_sum, rnd_shift;
    logic        [OUT_WIDTH-1:0]  clip_val;
    logic                         clip_sat;
    logic                         beat;

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
    assign bias_ext = {{(ACC_WIDTH-PROD_WIDTH){bias_tdata[PROD_WIDTH-1]}}, bias_tdata};
    assign beat     = prod_tvalid && prod_tready;

    // State register plus accumulator and result registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            res_data_reg <= '0;
            res_sat_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            if (state_reg == ROUND) begin
                res_data_reg <= clip_val;
                res_sat_reg  <= clip_sat;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (beat) begin
                    acc_next   = prod_ext + bias_ext;
                    cnt_next   = CNT_W'(1);
                    state_next = (NUM_TERMS == 1) ? ROUND : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_next = acc_reg + prod_ext;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
                        state_next = ROUND;
                    end
                end
            end
            ROUND: state_next = OUT;
            OUT: begin
                if (res_tready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One spare bit keeps the rounding offset from overflowing a full-scale accumulator.
    always_comb begin
        rnd_sum   = {acc_reg[ACC_WIDTH-1], acc_reg} + RND_HALF;
        rnd_shift = rnd_sum >>> SHIFT;
        clip_sat  = 1'b0;
        clip_val  = rnd_shift[OUT_WIDTH-1:0];
        if (rnd_shift > MAX_OUT) begin
            clip_val = MAX_OUT[OUT_WIDTH-1:0];
            clip_sat = 1'b1;
        end else if (rnd_shift < MIN_OUT) begin
            clip_val = MIN_OUT[OUT_WIDTH-1:0];
            clip_sat = 1'b1;
        end
`ifdef DECODER_ACC_RELU_EN
        if (clip_val[OUT_WIDTH-1]) begin
            clip_val = '0;
        end
`endif
    end

    always_comb begin
        prod_tready = (state_reg == IDLE) || (state_reg == ACC);
        res_tvalid  = (state_reg == OUT);
        busy        = (state_reg != IDLE);
        res_tdata   = res_data_reg;
        res_sat     = res_sat_reg;
    end

endmodule
